frame_loader: RTL

//  Consumes the word stream from the SPI frame reader (data, address, one-cycle

---
 rtl/frame_loader.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/frame_loader.sv
// Double-buffered frame store fed by the SPI word stream; the writer fills the back
// bank in address order and the banks swap on a display frame sync once a full frame lands.
module frame_loader #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 11,
    parameter int FRAME_WORDS = 1024
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  writeStrobe,
    input  logic                  frameSync,
    input  logic [ADDR_WIDTH-1:0] readAddress,
    output logic [DATA_WIDTH-1:0] readData,
    output logic                  frontSelect,
    output logic                  swapPending,
    output logic [7:0]            frameCount,
    output logic                  seqError,
    output logic                  overrun
);

    localparam int IDX_W = $clog2(2 * FRAME_WORDS);
    localparam logic [ADDR_WIDTH:0] FW_EXT   = (ADDR_WIDTH + 1)'(FRAME_WORDS);
    localparam logic [ADDR_WIDTH:0] LAST_EXT = (ADDR_WIDTH + 1)'(FRAME_WORDS - 1);
    localparam logic [IDX_W-1:0]    BANK_OFS = IDX_W'(FRAME_WORDS);

    typedef enum logic [1:0] {IDLE, LOADING, PENDING} state_t;

    state_t                state;
    state_t                state_next;
    logic [DATA_WIDTH-1:0] mem [0:2*FRAME_WORDS-1];
    logic [ADDR_WIDTH-1:0] exp_addr;

    logic             addr_in_range;
    logic             addr_is_last;
    logic             rd_in_range;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;

    logic write_en;
    logic exp_restart;
    logic exp_advance;
    logic seq_set;
    logic seq_clear;
    logic ovr_set;
    logic swap;

    // Bank offset: lower half is bank 0, upper half is bank 1; writes go to the back bank.
    assign addr_in_range = {1'b0, address} < FW_EXT;
    assign addr_is_last  = {1'b0, address} == LAST_EXT;
    assign rd_in_range   = {1'b0, readAddress} < FW_EXT;
    assign wr_idx        = IDX_W'(address) + (frontSelect ? '0 : BANK_OFS);
    assign rd_idx        = IDX_W'(readAddress) + (frontSelect ? BANK_OFS : '0);
    assign swapPending   = (state == PENDING);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (writeStrobe && address == '0)
                    state_next = addr_is_last ? PENDING : LOADING;
            end
            LOADING: begin
                if (writeStrobe) begin
                    if (address == '0)
                        state_next = addr_is_last ? PENDING : LOADING;
                    else if (address == exp_addr && addr_in_range)
                        state_next = addr_is_last ? PENDING : LOADING;
                    else
                        state_next = IDLE;
                end
            end
            PENDING: begin
                if (frameSync) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        write_en    = 1'b0;
        exp_restart = 1'b0;
        exp_advance = 1'b0;
        seq_set     = 1'b0;
        seq_clear   = 1'b0;
        ovr_set     = 1'b0;
        swap        = 1'b0;
        case (state)
            IDLE: begin
                if (writeStrobe && address == '0) begin
                    write_en    = 1'b1;
                    exp_restart = 1'b1;
                    seq_clear   = 1'b1;
                end
            end
            LOADING: begin
                if (writeStrobe) begin
                    if (address == '0) begin
                        write_en    = 1'b1;
                        exp_restart = 1'b1;
                    end else if (address == exp_addr && addr_in_range) begin
                        write_en    = 1'b1;
                        exp_advance = 1'b1;
                    end else begin
                        seq_set = 1'b1;
                    end
                end
            end
            PENDING: begin
                ovr_set = writeStrobe;
                swap    = frameSync;
            end
            default: ;
        endcase
    end

    // A swap clears overrun even if a word is dropped on the same edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            exp_addr    <= '0;
            frontSelect <= 1'b0;
            frameCount  <= 8'd0;
            seqError    <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (exp_restart)      exp_addr <= ADDR_WIDTH'(1);
            else if (exp_advance) exp_addr <= exp_addr + ADDR_WIDTH'(1);
            if (seq_set)        seqError <= 1'b1;
            else if (seq_clear) seqError <= 1'b0;
            if (swap) begin
                frontSelect <= ~frontSelect;
                frameCount  <= frameCount + 8'd1;
                overrun     <= 1'b0;
            end else if (ovr_set) begin
                overrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (write_en) mem[wr_idx] <= data;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)           readData <= '0;
        else if (rd_in_range) readData <= mem[rd_idx];
        else                  readData <= '0;
    end

endmodule
